mac_burst_scheduler: RTL
========================

// Module: mac_burst_scheduler
// PURPOSE
//  Shares one multiply-accumulate datapath (acc = acc + a*b, 2*DATA_WIDTH wide) among
//  NUM_REQ requesters. Each requester sends a burst of operand pairs ending in a "last" beat.
//  A requester is granted the datapath for a whole burst; arbitration between bursts is
//  round-robin. The block returns one accumulated dot-product result per burst over a
//  valid/ready output channel, tagged with the requester id and beat count.
// PARAMETERS
//  DATA_WIDTH  16  operand width; accumulator/result width is 2*DATA_WIDTH
//  NUM_REQ     2   number of requesters (>=2)
//  ID_W        1   width of out_id; must satisfy 2**ID_W >= NUM_REQ
//  CNT_W       8   width of out_beats (beat counter, saturating)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst_n      in   1                   asynchronous active-low reset
//  req_valid  in   NUM_REQ             per-requester beat valid
//  req_ready  out  NUM_REQ             per-requester beat accept (one-hot or zero)
//  req_a      in   NUM_REQ*DATA_WIDTH  operand a; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_b      in   NUM_REQ*DATA_WIDTH  operand b, same packing as req_a
//  req_last   in   NUM_REQ             final beat of the burst
//  out_valid  out  1                   result available
//  out_ready  in   1                   result consumer accept
//  out_data   out  2*DATA_WIDTH        accumulated sum of a*b over the burst
//  out_id     out  ID_W                index of the requester that owns the result
//  out_beats  out  CNT_W               beats in the burst, saturating at 2**CNT_W-1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, acc=0, beat count=0, grant=0, rr_last=NUM_REQ-1.
//   req_ready=0, out_valid=0, out_data=0, out_id=0, out_beats=0. A burst in progress is dropped.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: req_ready=0. If any req_valid is high, grant the first valid index searching upward
//   from rr_last+1 with wrap. Register the grant, clear acc and count, go to BUSY.
//   The grant is visible on req_ready one cycle after req_valid is sampled.
//  BUSY: req_ready[grant]=1; all other bits are 0. A beat transfers when req_valid[grant]
//   and req_ready[grant] are both high. On a beat: acc <= acc + a*b, where a*b is an unsigned
//   2*DATA_WIDTH product and the sum is taken modulo 2**(2*DATA_WIDTH). The count increments
//   and saturates. If req_valid[grant] drops mid-burst, the grant is held and the block waits.
//   Other requesters stay blocked.
//  Beat with req_last=1: out_data <= acc + a*b, out_beats <= count+1 (saturated),
//   out_id <= grant, state -> DONE. out_valid rises on the next cycle.
//  DONE: out_valid=1 and req_ready=0. out_data, out_id and out_beats stay stable until
//   out_ready=1. On the out_valid&&out_ready cycle: rr_last <= grant, state -> IDLE,
//   out_valid drops on the next cycle.
//  Minimum burst-to-burst turnaround is 4 cycles for a 1-beat burst:
//   IDLE, BUSY beat, DONE accept, IDLE.
//  req_a, req_b and req_last of non-granted requesters are ignored.
//  out_valid is never retracted without a handshake.
//  Signed arithmetic is not supported.
// TESTING
//  1 Single burst: DATA_WIDTH=16, req0 sends (3,4), then (5,6,last), out_ready=1
//    -> out_data=42, out_id=0, out_beats=2, exactly one out_valid pulse.
//  2 Round-robin: after reset, req0 and req1 both hold 1-beat bursts
//    -> req0 is served first, then req1, then req0 again. req_ready is never asserted
//    for two requesters at once.
//  3 Wrap: req1 sends (0xFFFF,0xFFFF), then (0xFFFF,0xFFFF,last)
//    -> out_data=0xFFFC0002, out_id=1.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1 with stable
//    out_data/out_id/out_beats, and req_ready=0 throughout.
//    Set out_ready=1 -> a single accept, then return to IDLE.
//  5 Reset mid-burst: pull rst_n low after 2 of 4 beats -> all outputs are 0 immediately.
//    Then a new burst (2,2,last) -> out_data=4.
//  6 Stall and saturation: with CNT_W=2, req0 sends 5 beats of (1,1) with req_valid
//    gapped between beats -> out_beats=3, out_data=5, and req1 is never granted mid-burst.

Source files
------------

// File: rtl/mac_burst_scheduler.sv
// mac_burst_scheduler: one shared multiply-accumulate datapath serving NUM_REQ requesters.
// A requester owns the datapath for a whole burst. Bursts are arbitrated round-robin, and
// each burst yields one tagged dot-product result on a valid/ready output channel.
module mac_burst_scheduler #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ID_W       = 1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2*DATA_WIDTH-1:0]       out_data,
   output logic [ID_W-1:0]               out_id,
   output logic [CNT_W-1:0]              out_beats
);

   localparam int unsigned AccW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [ID_W-1:0]     r_grant;
   logic [ID_W-1:0]     r_rr_last;
   logic [AccW-1:0]     r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic [AccW-1:0]     r_out_data;
   logic [ID_W-1:0]     r_out_id;
   logic [CNT_W-1:0]    r_out_beats;

   logic [ID_W-1:0]       w_pick;
   logic                  w_found;
   logic                  w_any_valid;
   logic                  w_start;
   logic [DATA_WIDTH-1:0] w_a;
   logic [DATA_WIDTH-1:0] w_b;
   logic                  w_valid_g;
   logic                  w_last_g;
   logic [AccW-1:0]       w_prod;
   logic [AccW-1:0]       w_sum;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic                  w_beat;
   logic                  w_accept;

   assign w_any_valid = |req_valid;
   assign w_start     = (r_state == StIdle) && w_any_valid;
   assign out_valid   = (r_state == StDone);
   assign w_accept    = out_valid && out_ready;

   // Round-robin pick: first valid index above rr_last, then wrap to the low indices.
   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (!w_found && req_valid[j] && (j > int'(r_rr_last))) begin
            w_pick  = ID_W'(j);
            w_found = 1'b1;
         end
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (!w_found && req_valid[j] && (j <= int'(r_rr_last))) begin
            w_pick  = ID_W'(j);
            w_found = 1'b1;
         end
      end
   end

   // Select the granted requester's beat; everyone else's operands are ignored.
   always_comb begin
      w_a       = '0;
      w_b       = '0;
      w_valid_g = 1'b0;
      w_last_g  = 1'b0;
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (r_grant == ID_W'(j)) begin
            w_a       = req_a[j*DATA_WIDTH +: DATA_WIDTH];
            w_b       = req_b[j*DATA_WIDTH +: DATA_WIDTH];
            w_valid_g = req_valid[j];
            w_last_g  = req_last[j];
         end
      end
   end

   // Ready is one-hot on the granted requester while a burst is open, zero otherwise.
   always_comb begin
      req_ready = '0;
      if (r_state == StBusy) begin
         for (int j = 0; j < int'(NUM_REQ); j++) begin
            req_ready[j] = (r_grant == ID_W'(j));
         end
      end
   end

   // Unsigned full-width product; the sum wraps modulo 2**AccW.
   assign w_prod    = {{DATA_WIDTH{1'b0}}, w_a} * {{DATA_WIDTH{1'b0}}, w_b};
   assign w_sum     = r_acc + w_prod;
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   assign w_beat    = (r_state == StBusy) && w_valid_g;

   // Next-state logic for the IDLE -> BUSY -> DONE -> IDLE burst cycle.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_any_valid) begin
               w_state_next = StBusy;
            end
         end
         StBusy: begin
            if (w_beat && w_last_g) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Grant and round-robin pointer; rr_last only moves once the result is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant   <= '0;
         r_rr_last <= ID_W'(NUM_REQ - 1);
      end else begin
         if (w_start) begin
            r_grant <= w_pick;
         end
         if (w_accept) begin
            r_rr_last <= r_grant;
         end
      end
   end

   // Accumulator and saturating beat counter, cleared when a new burst is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_start) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_beat && !w_last_g) begin
         r_acc <= w_sum;
         r_cnt <= w_cnt_inc;
      end
   end

   // Result registers, loaded on the last beat and held until the next burst finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_id    <= '0;
         r_out_beats <= '0;
      end else if (w_beat && w_last_g) begin
         r_out_data  <= w_sum;
         r_out_id    <= r_grant;
         r_out_beats <= w_cnt_inc;
      end
   end

   assign out_data  = r_out_data;
   assign out_id    = r_out_id;
   assign out_beats = r_out_beats;

endmodule
